multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit.sv | 144 ++++++++++++++
 tb/tb_multicycle_control_unit.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: five-state FETCH/DECODE/EXEC/MEM/WB controller with memory timeout and retire counter.
// Define CTRL_JAL_EN to decode jal (1101111); otherwise that opcode is illegal.
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int RETIRE_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          opcode,
    input  logic                stall,
    input  logic                mem_ready,
    input  logic                branch_taken,
    output logic                pc_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                alu_src,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_src,
    output logic [1:0]          wb_sel,
    output logic [2:0]          state,
    output logic                instr_done,
    output logic                illegal,
    output logic                timeout_err,
    output logic [RETIRE_W-1:0] instret
);
    typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [7:0] TO_LIM  = 8'(MEM_TIMEOUT - 2);
`ifdef CTRL_JAL_EN
    localparam bit JAL_EN = 1'b1;
`else
    localparam bit JAL_EN = 1'b0;
`endif
    state_t st, nxt;
    logic [6:0] op_q;
    logic [7:0] wait_cnt;
    function automatic logic legal(input logic [6:0] op);
        return (op inside {OP_R, OP_ADDI, OP_LD, OP_SD, OP_BEQ, OP_JALR}) || (JAL_EN && op == OP_JAL);
    endfunction
    assign state = st;
    always_comb begin
        nxt = st;
        {pc_write, ir_write, reg_write, mem_read, mem_write, alu_src, instr_done, illegal} = '0;
        alu_op = 2'b00;
        pc_src = 2'b00;
        wb_sel = 2'b00;
        case (st)
            FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    nxt      = DECODE;
                end
            end
            DECODE: begin
                illegal = !legal(opcode);
                nxt     = illegal ? FETCH : EXEC;
            end
            EXEC: begin
                nxt = WB;
                case (op_q)
                    OP_R:         alu_op = 2'b10;
                    OP_ADDI:      alu_src = 1'b1;
                    OP_LD, OP_SD: begin
                        alu_src = 1'b1;
                        nxt     = MEM;
                    end
                    OP_BEQ: begin
                        alu_op     = 2'b01;
                        pc_src     = 2'b01;
                        pc_write   = branch_taken;
                        instr_done = 1'b1;
                        nxt        = FETCH;
                    end
                    OP_JALR: begin
                        alu_src  = 1'b1;
                        pc_src   = 2'b10;
                        pc_write = 1'b1;
                        wb_sel   = 2'b10;
                    end
                    OP_JAL: begin
                        pc_src   = 2'b11;
                        pc_write = JAL_EN;
                        wb_sel   = 2'b10;
                        nxt      = JAL_EN ? WB : FETCH;
                    end
                    default: nxt = FETCH;
                endcase
            end
            MEM: begin
                mem_write  = op_q == OP_SD;
                mem_read   = op_q != OP_SD;
                instr_done = mem_ready && op_q == OP_SD;
                nxt        = !mem_ready ? MEM : (op_q == OP_SD ? FETCH : WB);
            end
            WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                wb_sel     = op_q == OP_LD ? 2'b01 : ((op_q == OP_JALR || op_q == OP_JAL) ? 2'b10 : 2'b00);
                nxt        = FETCH;
            end
            default: nxt = FETCH;
        endcase
        if (stall) begin
            {pc_write, ir_write, reg_write, mem_read, mem_write, instr_done, illegal} = '0;
            nxt = st;
        end
        if (reset) begin
            {pc_write, ir_write, reg_write, mem_read, mem_write, alu_src, instr_done, illegal} = '0;
            alu_op = 2'b00;
            pc_src = 2'b00;
            wb_sel = 2'b00;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= FETCH;
            op_q        <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
            instret     <= '0;
        end else begin
            st <= nxt;
            if (st == DECODE && !stall) op_q <= opcode;
            if (instr_done) instret <= instret + 1'b1;
            // saturating count of consecutive non-ready cycles; error stays set until reset
            if ((st == FETCH || st == MEM) && !stall) begin
                wait_cnt <= mem_ready ? 8'd0 : wait_cnt + {7'd0, ~&wait_cnt};
                if (!mem_ready && wait_cnt >= TO_LIM) timeout_err <= 1'b1;
            end else if (!stall) begin
                wait_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: table-driven cycle vectors plus timeout and reset sequences.
module tb_multicycle_control_unit;
    localparam logic [6:0] RT = 7'b0110011, ADDI = 7'b0010011, LD = 7'b0000011, SD = 7'b0100011;
    localparam logic [6:0] BEQ = 7'b1100011, JALR = 7'b1100111, JAL = 7'b1101111, BAD = 7'b1111111;
    logic clk = 1'b0, reset = 1'b1, stall = 1'b0, mem_ready = 1'b0, branch_taken = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic pc_write, ir_write, reg_write, mem_read, mem_write, alu_src, instr_done, illegal, timeout_err;
    logic [1:0] alu_op, pc_src, wb_sel;
    logic [2:0] state;
    logic [31:0] instret;
    int n_chk = 0, n_fail = 0;
    typedef struct {
        logic rst, stl, rdy, bt;
        logic [6:0] op;
        logic [2:0] st;
        logic pcw, irw, rw, mr, mw, as;
        logic [1:0] aop, psrc, wbs;
        logic done, ill, terr;
        logic [7:0] iret;
    } vec_t;
    vec_t tbl[$];

    multicycle_control_unit #(.MEM_TIMEOUT(16), .RETIRE_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .stall(stall), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src), .alu_op(alu_op), .pc_src(pc_src),
        .wb_sel(wb_sel), .state(state), .instr_done(instr_done), .illegal(illegal),
        .timeout_err(timeout_err), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic v(input logic r, s, m, b, input logic [6:0] o, input logic [2:0] st,
                     input logic pcw, irw, rw, mr, mw, as, input logic [1:0] aop, psrc, wbs,
                     input logic done, ill, terr, input logic [7:0] iret);
        tbl.push_back('{r, s, m, b, o, st, pcw, irw, rw, mr, mw, as, aop, psrc, wbs, done, ill, terr, iret});
    endtask

    task automatic drive(input logic r, s, m, b, input logic [6:0] o);
        @(negedge clk);
        reset = r;
        stall = s;
        mem_ready = m;
        branch_taken = b;
        opcode = o;
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        // reset and addi
        v(1,0,1,0,ADDI, 0, 0,0,0,0,0,0, 0,0,0, 0,0,0, 0);
        v(0,0,1,0,ADDI, 0, 1,1,0,1,0,0, 0,0,0, 0,0,0, 0);
        v(0,0,0,0,ADDI, 1, 0,0,0,0,0,0, 0,0,0, 0,0,0, 0);
        v(0,0,0,0,RT,   2, 0,0,0,0,0,1, 0,0,0, 0,0,0, 0);
        v(0,0,0,0,RT,   4, 0,0,1,0,0,0, 0,0,0, 1,0,0, 0);
        v(0,0,0,0,RT,   0, 0,0,0,1,0,0, 0,0,0, 0,0,0, 1);
        // R-type
        v(0,0,1,0,RT,   0, 1,1,0,1,0,0, 0,0,0, 0,0,0, 1);
        v(0,0,0,0,RT,   1, 0,0,0,0,0,0, 0,0,0, 0,0,0, 1);
        v(0,0,0,0,LD,   2, 0,0,0,0,0,0, 2,0,0, 0,0,0, 1);
        v(0,0,0,0,LD,   4, 0,0,1,0,0,0, 0,0,0, 1,0,0, 1);
        // ld with three-cycle memory delay
        v(0,0,1,0,LD,   0, 1,1,0,1,0,0, 0,0,0, 0,0,0, 2);
        v(0,0,0,0,LD,   1, 0,0,0,0,0,0, 0,0,0, 0,0,0, 2);
        v(0,0,0,0,SD,   2, 0,0,0,0,0,1, 0,0,0, 0,0,0, 2);
        v(0,0,0,0,SD,   3, 0,0,0,1,0,0, 0,0,0, 0,0,0, 2);
        v(0,0,0,0,SD,   3, 0,0,0,1,0,0, 0,0,0, 0,0,0, 2);
        v(0,0,0,0,SD,   3, 0,0,0,1,0,0, 0,0,0, 0,0,0, 2);
        v(0,0,1,0,SD,   3, 0,0,0,1,0,0, 0,0,0, 0,0,0, 2);
        v(0,0,0,0,SD,   4, 0,0,1,0,0,0, 0,0,1, 1,0,0, 2);
        // beq taken then not taken
        v(0,0,1,0,BEQ,  0, 1,1,0,1,0,0, 0,0,0, 0,0,0, 3);
        v(0,0,0,0,BEQ,  1, 0,0,0,0,0,0, 0,0,0, 0,0,0, 3);
        v(0,0,0,1,BEQ,  2, 1,0,0,0,0,0, 1,1,0, 1,0,0, 3);
        v(0,0,1,0,BEQ,  0, 1,1,0,1,0,0, 0,0,0, 0,0,0, 4);
        v(0,0,0,0,BEQ,  1, 0,0,0,0,0,0, 0,0,0, 0,0,0, 4);
        v(0,0,0,0,BEQ,  2, 0,0,0,0,0,0, 1,1,0, 1,0,0, 4);
        // sd stalled in MEM with mem_ready high
        v(0,0,1,0,SD,   0, 1,1,0,1,0,0, 0,0,0, 0,0,0, 5);
        v(0,0,0,0,SD,   1, 0,0,0,0,0,0, 0,0,0, 0,0,0, 5);
        v(0,0,0,0,SD,   2, 0,0,0,0,0,1, 0,0,0, 0,0,0, 5);
        for (int i = 0; i < 5; i++) v(0,1,1,0,SD, 3, 0,0,0,0,0,0, 0,0,0, 0,0,0, 5);
        v(0,0,1,0,SD,   3, 0,0,0,0,1,0, 0,0,0, 1,0,0, 5);
        // jalr
        v(0,0,1,0,JALR, 0, 1,1,0,1,0,0, 0,0,0, 0,0,0, 6);
        v(0,0,0,0,JALR, 1, 0,0,0,0,0,0, 0,0,0, 0,0,0, 6);
        v(0,0,0,0,JALR, 2, 1,0,0,0,0,1, 0,2,2, 0,0,0, 6);
        v(0,0,0,0,JALR, 4, 0,0,1,0,0,0, 0,0,2, 1,0,0, 6);
        // unknown opcode, then stall dominating mem_ready in FETCH
        v(0,0,1,0,BAD,  0, 1,1,0,1,0,0, 0,0,0, 0,0,0, 7);
        v(0,0,0,0,BAD,  1, 0,0,0,0,0,0, 0,0,0, 0,1,0, 7);
        v(0,0,0,0,BAD,  0, 0,0,0,1,0,0, 0,0,0, 0,0,0, 7);
        v(0,1,1,0,JAL,  0, 0,0,0,0,0,0, 0,0,0, 0,0,0, 7);
        v(0,0,1,0,JAL,  0, 1,1,0,1,0,0, 0,0,0, 0,0,0, 7);
`ifdef CTRL_JAL_EN
        v(0,0,0,0,JAL,  1, 0,0,0,0,0,0, 0,0,0, 0,0,0, 7);
        v(0,0,0,0,JAL,  2, 1,0,0,0,0,0, 0,3,2, 0,0,0, 7);
        v(0,0,0,0,JAL,  4, 0,0,1,0,0,0, 0,0,2, 1,0,0, 7);
        v(0,0,0,0,JAL,  0, 0,0,0,1,0,0, 0,0,0, 0,0,0, 8);
`else
        v(0,0,0,0,JAL,  1, 0,0,0,0,0,0, 0,0,0, 0,1,0, 7);
        v(0,0,0,0,JAL,  0, 0,0,0,1,0,0, 0,0,0, 0,0,0, 7);
`endif
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].stl, tbl[i].rdy, tbl[i].bt, tbl[i].op);
            check($sformatf("vec%0d", i),
                  {6'd0, state, pc_write, ir_write, reg_write, mem_read, mem_write, alu_src, alu_op,
                   pc_src, wb_sel, instr_done, illegal, timeout_err, instret[7:0]},
                  {6'd0, tbl[i].st, tbl[i].pcw, tbl[i].irw, tbl[i].rw, tbl[i].mr, tbl[i].mw, tbl[i].as,
                   tbl[i].aop, tbl[i].psrc, tbl[i].wbs, tbl[i].done, tbl[i].ill, tbl[i].terr, tbl[i].iret});
        end
        // 14 non-ready FETCH cycles stay clean, the 15th sets the sticky timeout
        drive(1,0,0,0,ADDI);
        for (int i = 0; i < 14; i++) drive(0,0,0,0,ADDI);
        drive(0,0,0,0,ADDI);
        check("timeout_after14", {state, timeout_err}, {3'd0, 1'b0});
        drive(0,0,0,0,ADDI);
        check("timeout_after15", {state, timeout_err}, {3'd0, 1'b1});
        drive(0,0,1,0,ADDI);
        drive(0,0,0,0,ADDI);
        drive(0,0,0,0,ADDI);
        drive(0,0,0,0,ADDI);
        drive(0,0,1,0,LD);
        check("timeout_sticky", {timeout_err, instret}, {1'b1, 32'd1});
        drive(0,0,0,0,LD);
        drive(0,0,0,0,LD);
        // reset together with stall while in MEM
        drive(1,1,0,0,LD);
        check("reset_outputs", {state, pc_write, ir_write, reg_write, mem_read, mem_write, alu_src,
                                alu_op, pc_src, wb_sel, instr_done, illegal}, {3'd3, 14'd0});
        drive(0,1,0,0,LD);
        check("reset_state", {state, timeout_err}, {3'd0, 1'b0});
        check("reset_instret", instret, 32'd0);
        drive(0,0,0,0,LD);
        check("post_reset_fetch", {state, mem_read}, {3'd0, 1'b1});
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
